// File: rtl/led_shift_pkg.sv
// Shared constants for the LED shift sequencer: mode encoding, defaults and FSM state type.
package led_shift_pkg;

  localparam logic [1:0] MODE_R      = 2'd0;
  localparam logic [1:0] MODE_L      = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_FILL   = 2'd3;

  localparam int unsigned DEF_LED_W = 4;
  localparam int unsigned DEF_DIV   = 50_000_000;
  localparam int unsigned DEF_CNT_W = 26;

  // Stored pattern mode; encodings line up with the mode input.
  typedef enum logic [1:0] {
    StShiftR = MODE_R,
    StShiftL = MODE_L,
    StBounce = MODE_BOUNCE,
    StFill   = MODE_FILL
  } state_e;

  function automatic state_e decode_mode(input logic [1:0] m);
    return state_e'(m);
  endfunction

endpackage

// File: rtl/led_prescaler.sv
// Step-rate prescaler: counts enabled cycles and strobes step on the last count of each period.
module led_prescaler
  import led_shift_pkg::*;
#(
  parameter int unsigned DIV   = DEF_DIV,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic step
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  assign step = en && (cnt_q == CntMax);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (en) begin
      if (cnt_q == CntMax) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/led_shift_seq.sv
// LED pattern sequencer: rotate right/left, bounce or fill, advancing one step per prescaler period.
module led_shift_seq
  import led_shift_pkg::*;
#(
  parameter int unsigned LED_W = DEF_LED_W,
  parameter int unsigned DIV   = DEF_DIV,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  output logic [LED_W-1:0] led,
  output logic             tick,
  output logic             dir_left
);

  localparam logic [LED_W-1:0] LedMsb  = {1'b1, {(LED_W-1){1'b0}}};
  localparam logic [LED_W-1:0] LedLsb  = LED_W'(1);
  localparam logic [LED_W-1:0] LedBit1 = LED_W'(2);
  localparam logic [LED_W-1:0] LedNm2  = LedMsb >> 1;

  state_e state_q;
  state_e next_mode;
  logic   step;
  logic   led_onehot;
  logic   bounce_left;

  led_prescaler #(
    .DIV   (DIV),
    .CNT_W (CNT_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .step (step)
  );

  assign next_mode  = decode_mode(mode);
  assign led_onehot = $onehot(led);

  // Entering bounce keeps travelling the way the previous mode was moving.
  always_comb begin
    bounce_left = dir_left;
    unique case (state_q)
      StShiftL: bounce_left = 1'b1;
      StShiftR,
      StFill:   bounce_left = 1'b0;
      default:  bounce_left = dir_left;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StShiftR;
      led      <= LedMsb;
      dir_left <= 1'b0;
      tick     <= 1'b0;
    end else begin
      tick <= step;
      if (step) begin
        state_q <= next_mode;
        unique case (next_mode)
          StShiftR: begin
            dir_left <= 1'b0;
            led      <= led_onehot ? {led[0], led[LED_W-1:1]} : LedMsb;
          end
          StShiftL: begin
            dir_left <= 1'b1;
            led      <= led_onehot ? {led[LED_W-2:0], led[LED_W-1]} : LedLsb;
          end
          StBounce: begin
            if (!led_onehot) begin
              led      <= LedMsb;
              dir_left <= 1'b0;
            end else if (bounce_left) begin
              if (led[LED_W-1]) begin
                led      <= LedNm2;
                dir_left <= 1'b0;
              end else begin
                led      <= led << 1;
                dir_left <= 1'b1;
              end
            end else begin
              if (led[0]) begin
                led      <= LedBit1;
                dir_left <= 1'b1;
              end else begin
                led      <= led >> 1;
                dir_left <= 1'b0;
              end
            end
          end
          StFill: begin
            dir_left <= 1'b0;
            led      <= (&led) ? '0 : {1'b1, led[LED_W-1:1]};
          end
          default: begin
            led      <= LedMsb;
            dir_left <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_shift_seq.sv
// Scoreboard bench for led_shift_seq (LED_W=4, DIV=3): expected steps queued, checked on each tick.
module tb_led_shift_seq;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [3:0] led;
  logic       tick;
  logic       dir_left;

  int total;
  int bad;
  logic [4:0] exp_q[$];
  logic tick_seen;

  led_shift_seq #(
    .LED_W (4),
    .DIV   (3),
    .CNT_W (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .led      (led),
    .tick     (tick),
    .dir_left (dir_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Push expected {led, dir_left} for an upcoming step.
  task automatic expect_step(input logic [3:0] l, input logic d);
    exp_q.push_back({l, d});
  endtask

  // Advance one edge, sample, and score any tick against the queue.
  task automatic cycle();
    logic [4:0] e;
    @(posedge clk);
    #1;
    tick_seen = tick;
    if (tick) begin
      if (exp_q.size() == 0) begin
        check_val("spurious_tick", 32'(tick), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_val("step_led", 32'(led), 32'(e[4:1]));
        check_val("step_dir", 32'(dir_left), 32'(e[0]));
      end
    end
  endtask

  task automatic wait_tick(input string tag, input int exp_n);
    int n;
    n = 0;
    tick_seen = 1'b0;
    while (!tick_seen && n < 16) begin
      cycle();
      n++;
    end
    if (!tick_seen) n = 99;
    check_val(tag, 32'(n), 32'(exp_n));
  endtask

  initial begin
    logic [3:0] frozen;
    total = 0;
    bad   = 0;
    tick_seen = 1'b0;
    rst  = 1'b1;
    en   = 1'b0;
    mode = 2'd0;

    // Reset held two cycles
    for (int i = 0; i < 2; i++) begin
      cycle();
      check_val("rst_led", 32'(led), 32'h8);
      check_val("rst_dir", 32'(dir_left), 32'd0);
      check_val("rst_tick", 32'(tick), 32'd0);
    end

    // SHIFT_R
    rst = 1'b0;
    en  = 1'b1;
    expect_step(4'b0100, 1'b0);
    wait_tick("first_tick_lat", 3);
    expect_step(4'b0010, 1'b0);
    wait_tick("shr_period", 3);
    expect_step(4'b0001, 1'b0);
    wait_tick("shr_period", 3);
    expect_step(4'b1000, 1'b0);
    wait_tick("shr_period", 3);

    // BOUNCE from 1000
    mode = 2'd2;
    expect_step(4'b0100, 1'b0);
    expect_step(4'b0010, 1'b0);
    expect_step(4'b0001, 1'b0);
    expect_step(4'b0010, 1'b1);
    expect_step(4'b0100, 1'b1);
    expect_step(4'b1000, 1'b1);
    expect_step(4'b0100, 1'b0);
    for (int i = 0; i < 7; i++) wait_tick("bounce_period", 3);

    // SHIFT_L to 1000, FILL to 1100, then SHIFT_L reloads LSB
    mode = 2'd1;
    expect_step(4'b1000, 1'b1);
    wait_tick("shl_period", 3);
    mode = 2'd3;
    expect_step(4'b1100, 1'b0);
    wait_tick("fill_period", 3);
    mode = 2'd1;
    expect_step(4'b0001, 1'b1);
    wait_tick("shl_reload", 3);

    // Mode glitch between steps must not matter
    expect_step(4'b0010, 1'b1);
    cycle();
    mode = 2'd3;
    cycle();
    mode = 2'd1;
    wait_tick("glitch_tick", 1);

    // Enable dropped one cycle after a tick
    cycle();
    en = 1'b0;
    frozen = led;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_val("frz_tick", 32'(tick), 32'd0);
      check_val("frz_led", 32'(led), 32'(frozen));
    end
    en = 1'b1;
    expect_step(4'b0100, 1'b1);
    wait_tick("resume_lat", 2);

    // Reset coincident with the step cycle
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    check_val("rst_step_tick", 32'(tick), 32'd0);
    check_val("rst_step_led", 32'(led), 32'h8);
    check_val("rst_step_dir", 32'(dir_left), 32'd0);
    rst = 1'b0;
    expect_step(4'b0001, 1'b1);
    wait_tick("post_rst_lat", 3);

    check_val("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_shift_seq.md
LED_SHIFT_SEQ -- requirements
Module: led_shift_seq

Interface
REQ-001 SHALL have parameter LED_W, default 4, meaning LED count (legal range ≥2).
REQ-002 SHALL have parameter DIV, default 50_000_000, meaning clk cycles per pattern step (legal range ≥1; 4 steps/s at 200 MHz).
REQ-003 SHALL have parameter CNT_W, default 26, meaning prescaler counter width (≥ clog2(DIV)).
REQ-004 SHALL have port clk  input  1  200 MHz clock; single clock domain, all logic rising-edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port en  input  1  run enable; 0 freezes prescaler and pattern.
REQ-007 SHALL have port mode  input  2  pattern select: 0 SHIFT_R, 1 SHIFT_L, 2 BOUNCE, 3 FILL.
REQ-008 SHALL have port led  output  LED_W  registered LED drive.
REQ-009 SHALL have port tick  output  1  one-cycle pulse, high in the cycle led takes a new step value.
REQ-010 SHALL have port dir_left  output  1  current travel direction (1 = toward MSB).

Function
REQ-011 Prescaler SHALL count 0..DIV-1 while en=1 and hold its value while en=0.
REQ-012 At cnt=DIV-1 with en=1, the prescaler SHALL wrap to 0 and raise an internal step strobe.
REQ-013 With DIV=1, a step SHALL occur every enabled cycle.
REQ-014 led, dir_left and tick SHALL be registered and update on the same edge; latency from step strobe to new led SHALL be 1 cycle.
REQ-015 tick SHALL be 0 in every cycle without a step, including all cycles with en=0.
REQ-016 mode SHALL be sampled only on a step; mode changes between steps SHALL have no effect until the next step.
REQ-017 SHIFT_R SHALL rotate one-hot right (1000→0100→0010→0001→1000), with dir_left=0.
REQ-018 SHIFT_L SHALL rotate one-hot left (0001→0010→0100→1000→0001), with dir_left=1.
REQ-019 BOUNCE SHALL move one-hot one position in dir_left.
REQ-020 In BOUNCE with dir_left=0 and led[0]=1, the step SHALL load bit1 and set dir_left=1; there SHALL be no dwell at endpoints.
REQ-021 In BOUNCE with dir_left=1 and led[LED_W-1]=1, the step SHALL load bit LED_W-2 and clear dir_left.
REQ-022 FILL SHALL set led to {1,led[LED_W-1:1]} unless led is all-ones, and SHALL clear led to all-zeros if it is (1000,1100,1110,1111,0000,1000); dir_left=0.
REQ-023 On a step into SHIFT_R or BOUNCE with led not exactly one-hot, led SHALL load MSB one-hot and dir_left SHALL load 0.
REQ-024 On a step into SHIFT_L with led not exactly one-hot, led SHALL load LSB one-hot and dir_left SHALL load 1.
REQ-025 On a step into BOUNCE from another mode with valid one-hot led, motion SHALL continue in the current dir_left.

Reset
REQ-026 While rst=1, the block SHALL drive led=MSB one-hot (4'b1000), dir_left=0, tick=0, prescaler=0 and stored mode=SHIFT_R.
REQ-027 rst SHALL take priority over en and over a coincident step.
REQ-028 Reset mid-count SHALL discard the partial count.
REQ-029 The first step after reset release SHALL occur DIV enabled cycles later.

Structure
REQ-030 Package led_shift_pkg SHALL hold the mode encoding constants (MODE_R=0, MODE_L=1, MODE_BOUNCE=2, MODE_FILL=3) and default DIV/LED_W constants.
REQ-031 The prescaler SHALL be the sub-module led_prescaler (parameters DIV, CNT_W; ports clk, rst, en, step).
REQ-032 The pattern FSM SHALL be implemented in led_shift_seq.

Verification (LED_W=4, DIV=3)
REQ-033 Bench SHALL cover reset: rst high 2 cycles -> led=1000, dir_left=0, tick=0; first tick 3 cycles after release with en=1.
REQ-034 Bench SHALL cover SHIFT_R, en=1: tick every 3rd cycle; led 1000,0100,0010,0001,1000.
REQ-035 Bench SHALL cover BOUNCE from 1000: led 0100,0010,0001,0010,0100,1000,0100; dir_left rises with the 0001→0010 step and falls with the 0100→1000→0100 turn.
REQ-036 Bench SHALL cover FILL reaching 1100, then mode=SHIFT_L: next tick led=0001, dir_left=1; mode toggled between ticks and restored before the tick -> no effect.
REQ-037 Bench SHALL cover en dropped 1 cycle after a tick for 5 cycles: led and tick frozen; after en returns, tick arrives 2 enabled cycles later.
REQ-038 Bench SHALL cover rst asserted in the step cycle: no tick, led=1000, prescaler restarts from 0.
